// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO write and read controllers.
// Gray/binary conversions work on zero-extended pointers up to 32 bits.
package fifo_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 3;
    localparam int PTR_MAX_W          = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    // Zero-extended input keeps the result exact for any narrower width.
    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero-extended upper bits stay zero.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = g[i] ^ b[i+1];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_gray_counter.sv
// Binary + Gray pointer register pair with increment enable.
// Next values are exported so the owner can compare against them early.
module gray_counter
    import fifo_pkg::*;
#(
    parameter int W = DEFAULT_ADDR_WIDTH + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray,
    output logic [W-1:0] bin_next,
    output logic [W-1:0] gray_next
);

    // Next pointer: wraps naturally at 2**W.
    always_comb begin
        bin_next  = inc ? bin + 1'b1 : bin;
        gray_next = W'(bin2gray(PTR_MAX_W'(bin_next)));
    end

    // Pointer registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
        end
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the asynchronous FIFO (write clock domain).
// Owns the write pointer and derives full / almost-full / level / overflow.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  clr_ovf,
    input  logic [ADDR_WIDTH:0]   rq2_rptr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] AF_LVL = PW'(AFULL_THRESH);

    logic                push;
    logic [ADDR_WIDTH:0] wbin;
    logic [ADDR_WIDTH:0] wbin_next;
    logic [ADDR_WIDTH:0] wgray_next;
    logic [ADDR_WIDTH:0] rbin;
    logic [ADDR_WIDTH:0] full_cmp;
    logic [ADDR_WIDTH:0] level_next;
    logic                full_next;
    logic                afull_next;

    // Accept only against the registered full flag; reset masks the strobe.
    always_comb begin
        push   = wr_en & ~full & rst_n;
        mem_we = push;
        waddr  = wbin[ADDR_WIDTH-1:0];
    end

    gray_counter #(
        .W (PW)
    ) u_wcnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (push),
        .bin       (wbin),
        .gray      (wptr),
        .bin_next  (wbin_next),
        .gray_next (wgray_next)
    );

    // Full when the next write pointer is one lap ahead of the read pointer.
    always_comb begin
        rbin       = PW'(gray2bin(PTR_MAX_W'(rq2_rptr)));
        full_cmp   = {~rq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1],
                      rq2_rptr[ADDR_WIDTH-2:0]};
        full_next  = (wgray_next == full_cmp);
        level_next = wbin_next - rbin;
        afull_next = (level_next >= AF_LVL);
    end

    // Registered status, folding push and read-pointer motion together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
        end else begin
            full        <= full_next;
            almost_full <= afull_next;
            wr_level    <= level_next;
        end
    end

    // Sticky overflow; a fresh overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule
